// File: rtl/rtc_pkg.sv
// Shared constants, set-FSM state type and BCD helper functions for the RTC
// time keeper.
package rtc_pkg;

    localparam int BCD_W = 8;

    localparam logic [BCD_W-1:0] SS_MAX = 8'h59;
    localparam logic [BCD_W-1:0] MM_MAX = 8'h59;
    localparam logic [BCD_W-1:0] HH_MAX = 8'h23;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        APPLY  = 2'd2,
        REJECT = 2'd3
    } set_fsm_t;

    // Both digits must be decimal; once they are, a plain compare orders BCD correctly.
    function automatic logic bcd_field_valid(input logic [BCD_W-1:0] value,
                                             input logic [BCD_W-1:0] max);
        bcd_field_valid = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] value,
                                                 input logic [BCD_W-1:0] max);
        if (value == max) begin
            bcd_inc = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            bcd_inc = {value[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {value[7:4], value[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (0..MAX) with synchronous load; wrap flags the
// terminal value so the caller can chain carries as wrap & inc.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = 8'h59
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] value,
    output logic             wrap
);

    logic [BCD_W-1:0] r_value;

    // Field register: load has priority over increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_value <= 8'h00;
        end else if (load) begin
            r_value <= load_val;
        end else if (inc) begin
            r_value <= bcd_inc(r_value, MAX);
        end else begin
            r_value <= r_value;
        end
    end

    assign value = r_value;
    assign wrap  = (r_value == MAX);

endmodule

// File: rtl/rtc_time_keeper.sv
// 24-hour BCD time keeper: divides tick_in to seconds, runs a checked set-time
// handshake and raises a sticky alarm flag on a match after each time update.
module rtc_time_keeper
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick_in,
    input  logic        run_en,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [23:0] set_time,
    output logic        set_err,
    input  logic        alarm_en,
    input  logic [23:0] alarm_time,
    input  logic        alarm_clr,
    output logic        alarm_flag,
    output logic [23:0] time_bcd,
    output logic        sec_pulse,
    output logic        day_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    set_fsm_t    r_state;
    set_fsm_t    w_state_nxt;
    logic [23:0] r_cap;
    logic [PW-1:0] r_presc;
    logic        r_set_ready, r_set_err, r_sec_pulse, r_day_pulse, r_upd, r_alarm_flag;

    logic        w_tick_q, w_adv, w_load, w_accept, w_set_ok;
    logic        w_ss_inc, w_mm_inc, w_hh_inc, w_day;
    logic        w_ss_wrap, w_mm_wrap, w_hh_wrap;
    logic [BCD_W-1:0] w_ss, w_mm, w_hh;

    assign w_tick_q = tick_in & run_en;
    assign w_adv    = w_tick_q & (r_presc == PRESC_LAST);
    assign w_load   = (r_state == APPLY);
    assign w_accept = set_valid & r_set_ready & (r_state == IDLE);
    assign w_set_ok = bcd_field_valid(r_cap[23:16], HH_MAX) &
                      bcd_field_valid(r_cap[15:8],  MM_MAX) &
                      bcd_field_valid(r_cap[7:0],   SS_MAX);

    // A load on the same edge as an advance discards the advance entirely.
    assign w_ss_inc = w_adv & ~w_load;
    assign w_mm_inc = w_ss_inc & w_ss_wrap;
    assign w_hh_inc = w_mm_inc & w_mm_wrap;
    assign w_day    = w_hh_inc & w_hh_wrap;

    bcd_mod_counter #(.MAX(SS_MAX)) u_ss (
        .clk(clk), .resetn(resetn), .inc(w_ss_inc), .load(w_load),
        .load_val(r_cap[7:0]), .value(w_ss), .wrap(w_ss_wrap)
    );
    bcd_mod_counter #(.MAX(MM_MAX)) u_mm (
        .clk(clk), .resetn(resetn), .inc(w_mm_inc), .load(w_load),
        .load_val(r_cap[15:8]), .value(w_mm), .wrap(w_mm_wrap)
    );
    bcd_mod_counter #(.MAX(HH_MAX)) u_hh (
        .clk(clk), .resetn(resetn), .inc(w_hh_inc), .load(w_load),
        .load_val(r_cap[23:16]), .value(w_hh), .wrap(w_hh_wrap)
    );

    // Set FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? CHECK : IDLE;
            CHECK:   w_state_nxt = w_set_ok ? APPLY : REJECT;
            APPLY:   w_state_nxt = IDLE;
            REJECT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state, capture register and handshake outputs. Ready stays low for
    // one extra IDLE cycle so a set always costs three cycles of not-ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cap       <= 24'h000000;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cap       <= w_accept ? set_time : r_cap;
            r_set_ready <= (w_state_nxt == IDLE) && (r_state == IDLE);
            r_set_err   <= (w_state_nxt == REJECT);
        end
    end

    // Tick prescaler; restarted by an applied set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_presc <= '0;
        end else if (w_load) begin
            r_presc <= '0;
        end else if (w_tick_q) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end else begin
            r_presc <= r_presc;
        end
    end

    // Pulses coincide with the new time; r_upd marks the cycle to compare the alarm.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_sec_pulse <= w_ss_inc;
            r_day_pulse <= w_day;
            r_upd       <= w_ss_inc | w_load;
        end
    end

    // Sticky alarm: a match set beats a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alarm_flag <= 1'b0;
        end else if (r_upd && alarm_en && ({w_hh, w_mm, w_ss} == alarm_time)) begin
            r_alarm_flag <= 1'b1;
        end else if (alarm_clr) begin
            r_alarm_flag <= 1'b0;
        end else begin
            r_alarm_flag <= r_alarm_flag;
        end
    end

    assign set_ready  = r_set_ready;
    assign set_err    = r_set_err;
    assign alarm_flag = r_alarm_flag;
    assign time_bcd   = {w_hh, w_mm, w_ss};
    assign sec_pulse  = r_sec_pulse;
    assign day_pulse  = r_day_pulse;

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Directed self-checking bench for rtc_time_keeper with TICK_DIV=4.
module tb_rtc_time_keeper;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tick_in, run_en, set_valid, set_ready, set_err;
    logic        alarm_en, alarm_clr, alarm_flag, sec_pulse, day_pulse;
    logic [23:0] set_time, alarm_time, time_bcd;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    rtc_time_keeper #(.TICK_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .tick_in(tick_in), .run_en(run_en),
        .set_valid(set_valid), .set_ready(set_ready), .set_time(set_time),
        .set_err(set_err), .alarm_en(alarm_en), .alarm_time(alarm_time),
        .alarm_clr(alarm_clr), .alarm_flag(alarm_flag), .time_bcd(time_bcd),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
    endtask

    // Drives one set request; ticks optional during CHECK/APPLY cycles.
    task automatic do_set(input logic [23:0] v, input logic exp_err, input logic [1:0] tick_mask);
        set_valid = 1'b1;
        set_time  = v;
        step();
        set_valid = 1'b0;
        chk("set_c1_ready", {23'd0, set_ready}, 24'd0);
        chk("set_c1_err", {23'd0, set_err}, 24'd0);
        tick_in = tick_mask[0];
        step();
        chk("set_c2_err", {23'd0, set_err}, {23'd0, exp_err});
        chk("set_c2_ready", {23'd0, set_ready}, 24'd0);
        tick_in = tick_mask[1];
        step();
        tick_in = 1'b0;
        chk("set_c3_ready", {23'd0, set_ready}, 24'd0);
        chk("set_c3_err", {23'd0, set_err}, 24'd0);
        chk("set_c3_sec", {23'd0, sec_pulse}, 24'd0);
        step();
        chk("set_c4_ready", {23'd0, set_ready}, 24'd1);
    endtask

    initial begin
        resetn = 1'b0; tick_in = 1'b0; run_en = 1'b1; set_valid = 1'b0;
        set_time = 24'h000000; alarm_en = 1'b0; alarm_time = 24'h000000; alarm_clr = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();

        // 1: reset state and 8 ticks
        chk("rst_time", time_bcd, 24'h000000);
        chk("rst_ready", {23'd0, set_ready}, 24'd1);
        chk("rst_err", {23'd0, set_err}, 24'd0);
        chk("rst_flag", {23'd0, alarm_flag}, 24'd0);
        chk("rst_sec", {23'd0, sec_pulse}, 24'd0);
        chk("rst_day", {23'd0, day_pulse}, 24'd0);
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            do_tick();
            chk("t1_time", time_bcd, 24'(i / 4));
            chk("t1_sec", {23'd0, sec_pulse}, {23'd0, (i % 4) == 0});
            if (sec_pulse) pulses++;
        end
        chk("t1_npulse", 24'(pulses), 24'd2);

        // 2: day rollover
        do_set(24'h235958, 1'b0, 2'b00);
        chk("t2_loaded", time_bcd, 24'h235958);
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            do_tick();
            chk("t2_time", time_bcd, (i < 4) ? 24'h235958 : (i < 8) ? 24'h235959 : 24'h000000);
            chk("t2_day", {23'd0, day_pulse}, {23'd0, i == 8});
            if (day_pulse) pulses++;
        end
        step();
        chk("t2_day_after", {23'd0, day_pulse}, 24'd0);
        chk("t2_nday", 24'(pulses), 24'd1);

        // 3: invalid minutes rejected
        do_set(24'h006000, 1'b1, 2'b00);
        chk("t3_time", time_bcd, 24'h000000);
        step();
        chk("t3_err_gone", {23'd0, set_err}, 24'd0);

        // 4: load coincides with an advance; tick during CHECK also counts
        do_tick(); do_tick();
        chk("t4_pre", time_bcd, 24'h000000);
        do_set(24'h101010, 1'b0, 2'b11);
        chk("t4_loaded", time_bcd, 24'h101010);
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            chk("t4_time", time_bcd, (i < 4) ? 24'h101010 : 24'h101011);
            chk("t4_sec", {23'd0, sec_pulse}, {23'd0, i == 4});
        end

        // 5: alarm set, clear while holding, set beats clear
        alarm_time = 24'h000003;
        alarm_en   = 1'b1;
        do_set(24'h000000, 1'b0, 2'b00);
        for (int i = 1; i <= 12; i++) begin
            do_tick();
            chk("t5_flag_pre", {23'd0, alarm_flag}, 24'd0);
        end
        chk("t5_time", time_bcd, 24'h000003);
        run_en = 1'b0;
        step();
        chk("t5_flag_set", {23'd0, alarm_flag}, 24'd1);
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        chk("t5_flag_clr", {23'd0, alarm_flag}, 24'd0);
        do_tick(); step(); step();
        chk("t5_flag_hold", {23'd0, alarm_flag}, 24'd0);
        chk("t5_time_hold", time_bcd, 24'h000003);
        chk("t5_sec_hold", {23'd0, sec_pulse}, 24'd0);
        alarm_clr = 1'b1;
        do_set(24'h000003, 1'b0, 2'b00);
        chk("t5_flag_win", {23'd0, alarm_flag}, 24'd1);
        alarm_clr = 1'b0;
        alarm_en  = 1'b0;
        run_en    = 1'b1;

        // 6: reset during CHECK
        set_valid = 1'b1;
        set_time  = 24'h123456;
        step();
        set_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_time", time_bcd, 24'h000000);
        chk("t6_ready", {23'd0, set_ready}, 24'd1);
        chk("t6_err", {23'd0, set_err}, 24'd0);
        chk("t6_flag", {23'd0, alarm_flag}, 24'd0);
        chk("t6_sec", {23'd0, sec_pulse}, 24'd0);
        chk("t6_day", {23'd0, day_pulse}, 24'd0);
        step(); step();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_no_err", {23'd0, set_err}, 24'd0);
            chk("t6_time_after", time_bcd, 24'h000000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_time_keeper.md
Name: rtc_time_keeper

Overview:
Downstream consumer of the periodic single-cycle tick produced by the free-running pulse counter. Divides incoming ticks to 1 Hz. Maintains a 24-hour hh:mm:ss time in packed BCD, with a validated set-time handshake and a sticky alarm flag. Feeds the display and alarm logic.

Parameters:
TICK_DIV, 1000, number of tick_in pulses per second (>=1); prescaler width is $clog2(TICK_DIV) (min 1).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous, active-low reset
tick_in  input  1  single-cycle pulse from upstream counter
run_en  input  1  1 = time advances; 0 = tick_in ignored, prescaler and time hold
set_valid  input  1  set request; held until accepted
set_ready  output  1  block can accept set_time this cycle
set_time  input  24  {hh,mm,ss}, packed BCD, 8 bits per field
set_err  output  1  one-cycle pulse: last set_time was rejected as invalid
alarm_en  input  1  enables alarm match
alarm_time  input  24  {hh,mm,ss}, packed BCD alarm value
alarm_clr  input  1  clears alarm_flag
alarm_flag  output  1  sticky alarm indication
time_bcd  output  24  current {hh,mm,ss}, BCD
sec_pulse  output  1  one-cycle pulse per second advance
day_pulse  output  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (async, resetn=0) forces:
  - time_bcd=24'h000000, prescaler=0, FSM=IDLE.
  - set_ready=1, set_err=0, alarm_flag=0, sec_pulse=0, day_pulse=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 when tick_in & run_en.
  - The tick that arrives at TICK_DIV-1 wraps it to 0 and advances the second on that same edge.
  - With TICK_DIV=1, every tick is an advance.
- Advance (registered, 1 edge after the qualifying tick):
  - ss +1; 59 -> 00 carries into mm.
  - mm 59 -> 00 carries into hh.
  - hh 23 -> 00 asserts day_pulse.
  - sec_pulse and day_pulse are high for exactly the cycle in which the new time_bcd is visible.
- Arithmetic: per-field BCD; low digit 9 -> 0 with carry into the tens digit. No binary intermediate is visible on outputs.
- Set FSM, states IDLE, CHECK, APPLY, REJECT:
  - IDLE: set_ready=1. set_valid & set_ready captures set_time -> CHECK.
  - CHECK (1 cycle): checks every digit <=9, ss/mm tens <=5, hh <=8'h23. Valid -> APPLY, else -> REJECT.
  - APPLY (1 cycle): time_bcd <= captured value; prescaler <= 0; -> IDLE.
  - REJECT (1 cycle): set_err=1; time unchanged; -> IDLE.
  - set_ready=0 in CHECK, APPLY and REJECT. Accept-to-ready latency is 3 cycles.
- Simultaneous events:
  - APPLY and a second advance on the same edge: the load wins, the advance is discarded, and sec_pulse/day_pulse stay 0.
  - Ticks during CHECK still count in the prescaler.
- Alarm:
  - Compare is evaluated only on a cycle where time_bcd was just updated (advance or APPLY).
  - If alarm_en and time_bcd==alarm_time, alarm_flag <= 1.
  - alarm_clr clears the flag; a set on the same cycle wins over clr.
  - Holding at the match time (run_en=0) does not re-set the flag after a clear.
- run_en=0: no advances or pulses. The set handshake still works.
- Reset mid-operation returns everything to reset values immediately. An in-flight set is dropped.

Decomposition:
- Shared package rtc_pkg:
  - Field width constant BCD_W=8.
  - Max constants SS_MAX=8'h59, MM_MAX=8'h59, HH_MAX=8'h23.
  - set_fsm_t enum {IDLE,CHECK,APPLY,REJECT}.
  - Function bcd_field_valid(value, max).
- Sub-module bcd_mod_counter (param MAX): 2-digit BCD, inputs inc/load/load_val, outputs value/wrap. Instantiated three times (ss, mm, hh), with carry chained via wrap & inc.

Test Plan:
1. TICK_DIV=4; reset; 8 ticks with run_en=1 -> time_bcd=000002, 2 sec_pulses each 1 cycle wide, no change between ticks 1-3.
2. set 235958, then 8 ticks -> 235959 then 000000, day_pulse asserted exactly once, coincident with 000000.
3. set_time=006000 (invalid mm) -> set_err pulses 2 cycles after accept; time unchanged; set_ready low 3 cycles, then high.
4. Set is applied on the same edge that would advance the second -> time equals loaded value, sec_pulse=0, prescaler restarts (next advance after 4 ticks).
5. alarm_time=000003, alarm_en=1; run to 000003 -> alarm_flag=1. alarm_clr with run_en=0 -> flag stays 0. alarm_clr on the match cycle -> flag=1.
6. Assert resetn=0 mid-CHECK with time 123456 -> all outputs to reset values asynchronously, set_err never pulses.
